// File: rtl/mem_initiator.sv
// Single-port memory initiator: turns host read/write/RMW requests into memory port cycles.
// Optional read-modify-write support is compiled in with `define MEM_INITIATOR_RMW_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a host request, req_ready high
// ISSUE | address (and write data/strobe) presented to the memory
// WAIT  | memory returning data; captured into the response or merge word
// MERGE | RMW only: merged word written back to memory
// WAIT2 | RMW only: memory echoes the merged word
// RESP  | response held until the host takes it
module mem_initiator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wea,
    output logic [5:0]  mem_addra,
    output logic [31:0] mem_dina,
    input  logic [31:0] mem_douta
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RESP  = 3'd5;
`ifdef MEM_INITIATOR_RMW_EN
    localparam logic [1:0] OP_RMW = 2'b10;
    localparam logic [2:0] MERGE  = 3'd3;
    localparam logic [2:0] WAIT2  = 3'd4;
`endif

    logic [2:0] state;
    logic       ready_en;
    logic       accept;
    logic       op_exec;

`ifdef MEM_INITIATOR_RMW_EN
    logic        rmw_q;
    logic [31:0] mask_q;
    logic [31:0] merge_word;

    // mem_dina still holds the latched write data while in WAIT
    assign merge_word = (mem_douta & ~mask_q) | (mem_dina & mask_q);
`else
    logic unused_mask;
    assign unused_mask = ^req_mask;
`endif

    // ready_en keeps req_ready low during reset even though state is IDLE
    assign req_ready = ready_en && (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        op_exec = 1'b0;
`ifdef MEM_INITIATOR_RMW_EN
        if ((req_op == OP_READ) || (req_op == OP_WRITE) || (req_op == OP_RMW))
            op_exec = 1'b1;
`else
        if ((req_op == OP_READ) || (req_op == OP_WRITE))
            op_exec = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addra <= 6'd0;
            mem_dina  <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
`ifdef MEM_INITIATOR_RMW_EN
            rmw_q     <= 1'b0;
            mask_q    <= 32'd0;
`endif
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    mem_wea <= 1'b0;
                    if (accept) begin
                        if (op_exec) begin
                            state     <= ISSUE;
                            mem_addra <= req_addr;
                            mem_dina  <= req_wdata;
                            mem_wea   <= (req_op == OP_WRITE);
`ifdef MEM_INITIATOR_RMW_EN
                            rmw_q     <= (req_op == OP_RMW);
                            mask_q    <= req_mask;
`endif
                        end else begin
                            // rejected op: answer immediately, memory untouched
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    mem_wea <= 1'b0;
                    state   <= WAIT;
                end

                WAIT: begin
`ifdef MEM_INITIATOR_RMW_EN
                    if (rmw_q) begin
                        mem_dina <= merge_word;
                        mem_wea  <= 1'b1;
                        state    <= MERGE;
                    end else begin
                        mem_wea   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= mem_douta;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end
`else
                    mem_wea   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem_douta;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
`endif
                end

`ifdef MEM_INITIATOR_RMW_EN
                MERGE: begin
                    mem_wea <= 1'b0;
                    state   <= WAIT2;
                end

                WAIT2: begin
                    mem_wea   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem_douta;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
`endif

                RESP: begin
                    mem_wea <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    mem_wea   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid  in  1  host request present; req_ready  out  1  initiator can accept.
REQ-004 SHALL have ports: req_op  in  2  operation (00 read, 01 write, 10 read-modify-write, 11 reserved).
REQ-005 SHALL have ports: req_addr  in  6  word address (3E = GPIO out, 3F = GPIO in).
REQ-006 SHALL have ports: req_wdata  in  32  write data; req_mask  in  32  RMW bit mask.
REQ-007 SHALL have ports: rsp_valid  out  1  response present; rsp_ready  in  1  host accepts response.
REQ-008 SHALL have ports: rsp_rdata  out  32  returned word; rsp_err  out  1  request rejected.
REQ-009 SHALL have ports: mem_wea  out  1; mem_addra  out  6; mem_dina  out  32 (all to memory port).
REQ-010 SHALL have port: mem_douta  in  32  memory data, valid the cycle after the memory samples mem_addra.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, MERGE, WAIT2, RESP.
REQ-012 SHALL assert req_ready only in IDLE; acceptance = req_valid & req_ready at a rising edge, latching op, addr, wdata, mask.
REQ-013 SHALL, on read or write acceptance, go IDLE->ISSUE->WAIT->RESP, one cycle each.
REQ-014 SHALL, in ISSUE, drive mem_addra = latched addr, mem_dina = latched wdata, mem_wea = 1 only for write.
REQ-015 SHALL, at the WAIT->RESP edge, capture mem_douta into rsp_rdata, so a write returns the memory's echo value.
REQ-016 SHALL deliver rsp_valid 3 rising edges after acceptance for read and write.
REQ-017 SHALL, for RMW, read in ISSUE, capture old word in WAIT, then drive mem_wea = 1 with mem_dina = (old & ~mask) | (wdata & mask) in MERGE.
REQ-018 SHALL, for RMW, capture the echo in WAIT2 and then enter RESP, so rsp_valid comes 5 edges after acceptance.
REQ-019 SHALL keep mem_wea = 0 in every state not explicitly listed, and hold mem_addra at the latched addr until IDLE.
REQ-020 SHALL, for reserved op 11, perform no memory access, go IDLE->RESP with rsp_rdata = 0 and rsp_err = 1, and assert rsp_valid 1 edge after acceptance.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-022 SHALL clear rsp_valid on the RESP exit edge; the next acceptance is possible no earlier than the following edge.
REQ-023 SHALL drive rsp_err = 0 for every executed read, write or RMW.
REQ-024 SHALL treat addresses 3E and 3F exactly like memory words; GPIO semantics belong to the memory.

Reset
REQ-025 SHALL, on rst_n = 0 asynchronously, force state IDLE and set mem_wea = 0, mem_addra = 0, mem_dina = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-026 SHALL drive req_ready = 0 while rst_n = 0, and 1 from the first edge after release.
REQ-027 SHALL, when reset arrives mid-operation including MERGE, abort with no further write and discard the response.

Configuration
REQ-028 SHALL compile RMW support only when macro MEM_INITIATOR_RMW_EN is defined.
REQ-029 SHALL, without MEM_INITIATOR_RMW_EN, omit MERGE and WAIT2 and handle op 10 exactly as reserved op 11 (rsp_err = 1, no access).

Verification
REQ-030 Bench SHALL cover: write op 01, addr 05, data DEADBEEF -> mem_wea high exactly one cycle; rsp_rdata DEADBEEF, rsp_err 0, rsp_valid at edge +3.
REQ-031 Bench SHALL cover: read op 00, addr 05 after that write -> rsp_rdata DEADBEEF, mem_wea never asserted.
REQ-032 Bench SHALL cover (with MEM_INITIATOR_RMW_EN): RMW on addr 05, mask 0000FFFF, wdata 00001234 -> write data DEAD1234, rsp_rdata DEAD1234, rsp_valid at edge +5.
REQ-033 Bench SHALL cover: op 11 -> no mem_wea; rsp_err 1, rsp_rdata 0 at edge +1. Without the macro, op 10 gives the same response.
REQ-034 Bench SHALL cover: rsp_ready held 0 for 4 cycles -> response stable; req_ready 0 until the cycle after rsp_ready = 1.
REQ-035 Bench SHALL cover: rst_n pulsed low during RMW MERGE -> mem_wea drops immediately, addr 05 keeps its old value, rsp_valid 0, FSM in IDLE.
